// File: rtl/iir_out_serializer.sv
// Purpose : buffers 32-bit filter samples in a FIFO and drains them onto a left-justified serial audio link.
// Latency : write at edge N -> pop at edge N+1 -> MSB on sdata after edge N+1; one word per 32*BCLK_DIV clocks.
// Backpr. : none upstream; a write while full is dropped and sets sticky overflow, an empty FIFO at a word boundary sends zeros and sets underrun.
//
// Ports   : clk / reset (synchronous, active-low) / clk_enable (freezes all state when low)
//           data_in + data_valid : sample write strobe from the filter
//           hold                 : pause serial output at the next word boundary
//           sclk, sdata, lrck    : serial link (sdata changes on sclk fall, MSB first)
//           fifo_full, fifo_empty, level : FIFO status; overflow, underrun : sticky error flags
// Option  : define IIR_SER_I2S_DELAY_EN for I2S framing (lrck leads the MSB by one bit period).
module iir_out_serializer #(
    parameter int DEPTH    = 8,
    parameter int BCLK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic [31:0]              data_in,
    input  logic                     data_valid,
    input  logic                     hold,
    output logic                     sclk,
    output logic                     sdata,
    output logic                     lrck,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level_q;
    logic [DW-1:0]   div_cnt;
    logic [4:0]      bit_cnt;
    logic [31:0]     shreg;
    logic            lrck_q, overflow_q, underrun_q;

    logic            pop, load_zero, lrck_tgl, push, div_wrap, word_end;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);
    assign div_wrap   = (div_cnt == DIV_LAST);
    assign word_end   = (state == RUN) && div_wrap && (bit_cnt == 5'd31);

    // A pop in the same cycle frees a slot, so a push while full is still taken.
    assign push = data_valid && clk_enable && (!fifo_full || pop);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_zero = 1'b0;
        lrck_tgl  = 1'b0;
        case (state)
            IDLE: begin
                // First word after IDLE never moves lrck.
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
`ifdef IIR_SER_I2S_DELAY_EN
                // Announce the next word one bit early, at the start of the LSB.
                if (div_wrap && bit_cnt == 5'd30) begin
                    lrck_tgl = 1'b1;
                end
`endif
                if (word_end) begin
                    if (hold) begin
                        state_nxt = HOLD;
`ifdef IIR_SER_I2S_DELAY_EN
                        // No next word follows, so take back the early toggle.
                        lrck_tgl  = 1'b1;
`endif
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
`ifndef IIR_SER_I2S_DELAY_EN
                        lrck_tgl = 1'b1;
`endif
                    end else begin
                        load_zero = 1'b1;
`ifndef IIR_SER_I2S_DELAY_EN
                        lrck_tgl = 1'b1;
`endif
                    end
                end
            end
            HOLD: begin
                if (!hold) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            lrck_q     <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else if (clk_enable) begin
            state <= state_nxt;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase

            if (data_valid && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (load_zero) begin
                underrun_q <= 1'b1;
            end
            if (lrck_tgl) begin
                lrck_q <= ~lrck_q;
            end

            if (state == RUN && !div_wrap) begin
                div_cnt <= div_cnt + DW'(1);
            end else begin
                div_cnt <= '0;
            end

            if (pop) begin
                shreg   <= mem[rd_ptr];
                bit_cnt <= '0;
            end else if (load_zero) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (state == RUN && div_wrap) begin
                shreg   <= {shreg[30:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    // sclk low for the first half of each bit, so sdata only moves on its fall.
    assign sclk     = (state == RUN) && (div_cnt >= DIV_HALF);
    assign sdata    = (state == RUN) && shreg[31];
    assign lrck     = lrck_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_iir_out_serializer.sv
module tb_iir_out_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_enable;
    logic [31:0] data_in;
    logic        data_valid;
    logic        hold;
    logic        sclk, sdata, lrck, fifo_full, fifo_empty, overflow, underrun;
    logic [3:0]  level;

    int          checks = 0;
    int          errors = 0;
    int          words_done = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        dv;
        logic [31:0] dat;
        logic        acc;
        logic [3:0]  exp_level;
        logic        exp_full;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[10];

    iir_out_serializer #(.DEPTH(8), .BCLK_DIV(4)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .clk_enable (clk_enable),
        .data_in    (data_in),
        .data_valid (data_valid),
        .hold       (hold),
        .sclk       (sclk),
        .sdata      (sdata),
        .lrck       (lrck),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .level      (level),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial receiver: shifts sdata on every sclk rise and checks each 32-bit word
    // against the scoreboard; an empty scoreboard means the link must carry zeros.
    initial begin
        logic [31:0] w;
        logic [31:0] e;
        int          nb;
        logic        ps;
        w  = '0;
        nb = 0;
        ps = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                nb = 0;
                ps = 1'b0;
            end else begin
                if (sclk === 1'b1 && ps === 1'b0) begin
                    w = {w[30:0], sdata};
                    nb++;
                    if (nb == 32) begin
                        e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'h0;
                        chk("serial_word", w, e);
                        words_done++;
                        nb = 0;
                    end
                end
                ps = sclk;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] y_w;
        int          rises;
        logic        ps;
        int          wd, wd0;

        //            dv    data           acc   level  full  ovf
        tbl[0] = '{1'b1, 32'hD000_0001, 1'b1, 4'd1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'hD000_0002, 1'b1, 4'd1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'hD000_0003, 1'b1, 4'd2, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'hD000_0004, 1'b1, 4'd3, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 32'hD000_0005, 1'b1, 4'd4, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 32'hD000_0006, 1'b1, 4'd5, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'hD000_0007, 1'b1, 4'd6, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 32'hD000_0008, 1'b1, 4'd7, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 32'hD000_0009, 1'b1, 4'd8, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 32'hD000_000A, 1'b0, 4'd8, 1'b1, 1'b1};

        rst_n      = 1'b0;
        clk_enable = 1'b1;
        data_in    = '0;
        data_valid = 1'b0;
        hold       = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_sclk",     32'(sclk),       32'd0);
        chk("rst_sdata",    32'(sdata),      32'd0);
        chk("rst_lrck",     32'(lrck),       32'd0);
        chk("rst_full",     32'(fifo_full),  32'd0);
        chk("rst_empty",    32'(fifo_empty), 32'd1);
        chk("rst_level",    32'(level),      32'd0);
        chk("rst_overflow", 32'(overflow),   32'd0);
        chk("rst_underrun", 32'(underrun),   32'd0);
        rst_n = 1'b1;
        tick();

        // Single sample followed by underrun
        data_valid = 1'b1;
        data_in    = 32'hA5A5_0F0F;
        sb_q.push_back(32'hA5A5_0F0F);
        tick();
        data_valid = 1'b0;
        chk("single_level_w",  32'(level),      32'd1);
        chk("single_empty_w",  32'(fifo_empty), 32'd0);
        chk("single_sdata_w",  32'(sdata),      32'd0);
        tick();
        chk("single_level_p",  32'(level), 32'd0);
        chk("single_msb",      32'(sdata), 32'd1);
        chk("single_sclk_p",   32'(sclk),  32'd0);
        chk("single_lrck_p",   32'(lrck),  32'd0);
        repeat (127) tick();
        chk("single_lrck_end", 32'(lrck),     32'd0);
        chk("single_und_end",  32'(underrun), 32'd0);
        tick();
        chk("und_lrck",        32'(lrck),     32'd1);
        chk("und_flag",        32'(underrun), 32'd1);
        chk("und_sdata",       32'(sdata),    32'd0);
        chk("single_words",    32'(words_done), 32'd1);
        rises = 0;
        ps    = sclk;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        chk("und_sclk_rises", 32'(rises), 32'd2);

        // Reset mid-word
        rst_n = 1'b0;
        tick();
        chk("midrst_level", 32'(level),      32'd0);
        chk("midrst_empty", 32'(fifo_empty), 32'd1);
        chk("midrst_sclk",  32'(sclk),       32'd0);
        chk("midrst_sdata", 32'(sdata),      32'd0);
        chk("midrst_lrck",  32'(lrck),       32'd0);
        chk("midrst_und",   32'(underrun),   32'd0);
        rst_n = 1'b1;
        sb_q.delete();
        tick();

        // Overflow: 10 back-to-back writes into an 8-deep FIFO
        wd0 = words_done;
        for (int i = 0; i < 10; i++) begin
            data_valid = tbl[i].dv;
            data_in    = tbl[i].dat;
            if (tbl[i].acc) sb_q.push_back(tbl[i].dat);
            tick();
            chk($sformatf("ovf_level_%0d", i), 32'(level),     32'(tbl[i].exp_level));
            chk($sformatf("ovf_full_%0d", i),  32'(fifo_full), 32'(tbl[i].exp_full));
            chk($sformatf("ovf_flag_%0d", i),  32'(overflow),  32'(tbl[i].exp_ovf));
        end
        data_valid = 1'b0;
        for (int c = 0; c < 1500 && sb_q.size() != 0; c++) tick();
        chk("ovf_drain", 32'(sb_q.size()), 32'd0);
        wd = words_done;
        for (int c = 0; c < 300 && words_done == wd; c++) tick();
        chk("ovf_words",    32'(words_done - wd0), 32'd10);
        chk("ovf_sticky",   32'(overflow),         32'd1);
        chk("ovf_underrun", 32'(underrun),         32'd1);
        chk("ovf_level_end", 32'(level),           32'd0);

        // Hold mid-word
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb_q.delete();
        tick();
        data_valid = 1'b1;
        data_in    = 32'h5A5A_C3C3;
        sb_q.push_back(32'h5A5A_C3C3);
        tick();
        data_valid = 1'b0;
        tick();
        repeat (40) tick();
        hold = 1'b1;
        repeat (88) tick();
        chk("hold_sclk",  32'(sclk),     32'd0);
        chk("hold_sdata", 32'(sdata),    32'd0);
        chk("hold_lrck",  32'(lrck),     32'd0);
        chk("hold_und",   32'(underrun), 32'd0);
        rises = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (sclk) rises++;
        end
        chk("hold_sclk_idle", 32'(rises), 32'd0);
        hold = 1'b0;
        tick();
        y_w        = 32'h8C5A_3C96;
        data_valid = 1'b1;
        data_in    = y_w;
        sb_q.push_back(y_w);
        tick();
        data_valid = 1'b0;
        chk("resume_sdata_w", 32'(sdata), 32'd0);
        chk("resume_level_w", 32'(level), 32'd1);
        tick();
        chk("resume_msb",  32'(sdata), 32'(y_w[31]));
        chk("resume_lrck", 32'(lrck),  32'd0);

        // clk_enable low mid-word: position k=22 -> second half of bit 5
        repeat (22) tick();
        clk_enable = 1'b0;
        for (int j = 0; j < 5; j++) begin
            data_valid = (j == 2);
            data_in    = 32'hDEAD_BEEF;
            tick();
            chk($sformatf("frz_sclk_%0d", j),  32'(sclk),  32'd1);
            chk($sformatf("frz_sdata_%0d", j), 32'(sdata), 32'(y_w[26]));
            chk($sformatf("frz_level_%0d", j), 32'(level), 32'd0);
        end
        data_valid = 1'b0;
        clk_enable = 1'b1;
        tick();
        chk("frz_level_after", 32'(level), 32'd0);
        wd = words_done;
        for (int c = 0; c < 200 && words_done == wd; c++) tick();
        chk("frz_word_seen",  32'(words_done - wd), 32'd1);
        chk("frz_sb_empty",   32'(sb_q.size()),     32'd0);
        chk("frz_no_ovf",     32'(overflow),        32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
